// File: rtl/id_ex_pipe.sv
// rtl/id_ex_pipe.sv - id->ex pipeline register with valid/ready handshake and one-entry skid buffer
// Optional stall/flush statistics counters are built when ID_EX_STAT_EN is defined.
module id_ex_pipe #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] inst_addr_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            rd_wen_i,
  input  logic [XLEN-1:0] base_addr_i,
  input  logic [XLEN-1:0] addr_offset_i,
  input  logic            id_valid_i,
  output logic            id_ready_o,
  output logic            ex_valid_o,
  input  logic            ex_ready_i,
  input  logic            hold_i,
  input  logic            flush_i,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_addr_o,
  output logic [XLEN-1:0] op1_o,
  output logic [XLEN-1:0] op2_o,
  output logic [4:0]      rd_addr_o,
  output logic            rd_wen_o,
  output logic [XLEN-1:0] base_addr_o,
  output logic [XLEN-1:0] addr_offset_o,
  output logic [31:0]     stall_cnt_o,
  output logic [31:0]     flush_cnt_o
);

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] inst_addr;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [4:0]      rd_addr;
    logic            rd_wen;
    logic [XLEN-1:0] base_addr;
    logic [XLEN-1:0] addr_offset;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  localparam entry_t NOP_ENTRY = '{inst: NOP_INST, inst_addr: '0, op1: '0, op2: '0,
                                   rd_addr: '0, rd_wen: 1'b0, base_addr: '0, addr_offset: '0};

  state_e state_q, state_d;
  entry_t m_q, m_d, s_q, s_d;
  entry_t in_entry;
  logic   xfer_in, rdy, xfer_out;

  assign in_entry = '{inst: inst_i, inst_addr: inst_addr_i, op1: op1_i, op2: op2_i,
                      rd_addr: rd_addr_i, rd_wen: rd_wen_i, base_addr: base_addr_i,
                      addr_offset: addr_offset_i};

  assign id_ready_o = (state_q != TWO);
  assign ex_valid_o = (state_q != EMPTY);
  assign xfer_in    = id_valid_i & id_ready_o;
  assign rdy        = ex_ready_i & ~hold_i;
  assign xfer_out   = ex_valid_o & rdy;

  // M is reloaded with NOP whenever it empties, so outputs stay purely registered.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    if (flush_i) begin
      state_d = EMPTY;
      m_d     = NOP_ENTRY;
      s_d     = NOP_ENTRY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (xfer_in) begin
            state_d = ONE;
            m_d     = in_entry;
          end
        end
        ONE: begin
          if (xfer_in && !xfer_out) begin
            state_d = TWO;
            s_d     = in_entry;
          end else if (xfer_in && xfer_out) begin
            m_d = in_entry;
          end else if (xfer_out) begin
            state_d = EMPTY;
            m_d     = NOP_ENTRY;
          end
        end
        TWO: begin
          if (xfer_out) begin
            state_d = ONE;
            m_d     = s_q;
            s_d     = NOP_ENTRY;
          end
        end
        default: begin
          state_d = EMPTY;
          m_d     = NOP_ENTRY;
          s_d     = NOP_ENTRY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      m_q     <= NOP_ENTRY;
      s_q     <= NOP_ENTRY;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

  assign inst_o        = m_q.inst;
  assign inst_addr_o   = m_q.inst_addr;
  assign op1_o         = m_q.op1;
  assign op2_o         = m_q.op2;
  assign rd_addr_o     = m_q.rd_addr;
  assign rd_wen_o      = m_q.rd_wen;
  assign base_addr_o   = m_q.base_addr;
  assign addr_offset_o = m_q.addr_offset;

`ifdef ID_EX_STAT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  // A flush counts only when it actually discards something.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (ex_valid_o && !rdy && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_i && (ex_valid_o || xfer_in) && (flush_cnt_q != 32'hFFFF_FFFF))
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = 32'd0;
  assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb/tb_id_ex_pipe.sv - directed table-driven bench for id_ex_pipe
// Counter expectations follow ID_EX_STAT_EN (zero when undefined).
module tb_id_ex_pipe;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] TAG = 32'hABC0_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst_i, inst_addr_i, op1_i, op2_i, base_addr_i, addr_offset_i;
  logic [4:0]  rd_addr_i;
  logic        rd_wen_i, id_valid_i, ex_ready_i, hold_i, flush_i;
  logic        id_ready_o, ex_valid_o, rd_wen_o;
  logic [31:0] inst_o, inst_addr_o, op1_o, op2_o, base_addr_o, addr_offset_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] stall_cnt_o, flush_cnt_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .inst_i(inst_i), .inst_addr_i(inst_addr_i), .op1_i(op1_i), .op2_i(op2_i),
    .rd_addr_i(rd_addr_i), .rd_wen_i(rd_wen_i), .base_addr_i(base_addr_i),
    .addr_offset_i(addr_offset_i), .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i), .hold_i(hold_i), .flush_i(flush_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .op1_o(op1_o), .op2_o(op2_o),
    .rd_addr_o(rd_addr_o), .rd_wen_o(rd_wen_o), .base_addr_o(base_addr_o),
    .addr_offset_o(addr_offset_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  typedef struct {
    logic        iv;
    logic [31:0] op1;
    logic [31:0] addr;
    logic        er;
    logic        hold;
    logic        flush;
    logic        ev;
    logic        ir;
    logic [31:0] e_op1;
    logic [31:0] e_addr;
    logic [31:0] e_stall;
    logic [31:0] e_flush;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] op1, input logic [31:0] addr,
                       input logic er, input logic hold, input logic flush);
    id_valid_i    = iv;
    op1_i         = op1;
    inst_i        = TAG + op1;
    op2_i         = ~op1;
    rd_addr_i     = op1[4:0];
    rd_wen_i      = 1'b1;
    inst_addr_i   = addr;
    base_addr_i   = addr;
    addr_offset_i = op1;
    ex_ready_i    = er;
    hold_i        = hold;
    flush_i       = flush;
  endtask

  initial begin
    //           iv  op1    addr    er   hold flush ev   ir   e_op1  e_addr  stall flush
    vecs[0]  = '{1'b1, 32'd1,  32'h10,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'd1,  32'h10,  32'd0, 32'd0};
    vecs[1]  = '{1'b1, 32'd2,  32'h14,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'd2,  32'h14,  32'd0, 32'd0};
    vecs[2]  = '{1'b1, 32'd3,  32'h18,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'd3,  32'h18,  32'd0, 32'd0};
    vecs[3]  = '{1'b0, 32'd0,  32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0,  32'h0,   32'd0, 32'd0};
    vecs[4]  = '{1'b1, 32'd4,  32'h20,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd4,  32'h20,  32'd0, 32'd0};
    vecs[5]  = '{1'b1, 32'd5,  32'h24,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd4,  32'h20,  32'd1, 32'd0};
    vecs[6]  = '{1'b1, 32'd6,  32'h28,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd4,  32'h20,  32'd2, 32'd0};
    vecs[7]  = '{1'b0, 32'd0,  32'h0,   1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'd5,  32'h24,  32'd2, 32'd0};
    vecs[8]  = '{1'b0, 32'd0,  32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0,  32'h0,   32'd2, 32'd0};
    vecs[9]  = '{1'b1, 32'd7,  32'h100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd7,  32'h100, 32'd2, 32'd0};
    vecs[10] = '{1'b1, 32'd8,  32'h104, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd7,  32'h100, 32'd3, 32'd0};
    vecs[11] = '{1'b1, 32'd9,  32'h108, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0,  32'h0,   32'd4, 32'd1};
    vecs[12] = '{1'b1, 32'd10, 32'h200, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd10, 32'h200, 32'd4, 32'd1};
    vecs[13] = '{1'b1, 32'd11, 32'h204, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'd0,  32'h0,   32'd5, 32'd2};
    vecs[14] = '{1'b1, 32'd12, 32'h300, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd12, 32'h300, 32'd5, 32'd2};
    vecs[15] = '{1'b0, 32'd0,  32'h0,   1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'd12, 32'h300, 32'd6, 32'd2};
    vecs[16] = '{1'b0, 32'd0,  32'h0,   1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'd12, 32'h300, 32'd7, 32'd2};
    vecs[17] = '{1'b0, 32'd0,  32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0,  32'h0,   32'd7, 32'd2};
    vecs[18] = '{1'b0, 32'd0,  32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0,  32'h0,   32'd7, 32'd2};

    rst_n = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    #12;
    rst_n = 1'b1;

    chk("reset ex_valid", {31'd0, ex_valid_o}, 32'd0);
    chk("reset id_ready", {31'd0, id_ready_o}, 32'd1);
    chk("reset inst", inst_o, NOP);
    chk("reset rd_wen", {31'd0, rd_wen_o}, 32'd0);
    chk("reset stall_cnt", stall_cnt_o, 32'd0);
    chk("reset flush_cnt", flush_cnt_o, 32'd0);

    for (int i = 0; i < 19; i++) begin
      logic [31:0] es, ef;
      drive(vecs[i].iv, vecs[i].op1, vecs[i].addr, vecs[i].er, vecs[i].hold, vecs[i].flush);
      @(posedge clk);
      #1;
`ifdef ID_EX_STAT_EN
      es = vecs[i].e_stall;
      ef = vecs[i].e_flush;
`else
      es = 32'd0;
      ef = 32'd0;
`endif
      chk($sformatf("v%0d ex_valid", i), {31'd0, ex_valid_o}, {31'd0, vecs[i].ev});
      chk($sformatf("v%0d id_ready", i), {31'd0, id_ready_o}, {31'd0, vecs[i].ir});
      chk($sformatf("v%0d op1", i), op1_o, vecs[i].e_op1);
      chk($sformatf("v%0d op2", i), op2_o, vecs[i].ev ? ~vecs[i].e_op1 : 32'd0);
      chk($sformatf("v%0d inst_addr", i), inst_addr_o, vecs[i].e_addr);
      chk($sformatf("v%0d inst", i), inst_o, vecs[i].ev ? TAG + vecs[i].e_op1 : NOP);
      chk($sformatf("v%0d rd_wen", i), {31'd0, rd_wen_o}, {31'd0, vecs[i].ev});
      chk($sformatf("v%0d stall_cnt", i), stall_cnt_o, es);
      chk($sformatf("v%0d flush_cnt", i), flush_cnt_o, ef);
    end

    // Fill both entries, then reset asynchronously mid-cycle.
    drive(1'b1, 32'd20, 32'h400, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b1, 32'd21, 32'h404, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("full id_ready", {31'd0, id_ready_o}, 32'd0);
    chk("full op1", op1_o, 32'd20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst ex_valid", {31'd0, ex_valid_o}, 32'd0);
    chk("async rst id_ready", {31'd0, id_ready_o}, 32'd1);
    chk("async rst inst", inst_o, NOP);
    chk("async rst op1", op1_o, 32'd0);
    chk("async rst stall_cnt", stall_cnt_o, 32'd0);
    chk("async rst flush_cnt", flush_cnt_o, 32'd0);
    @(negedge clk);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post rst ex_valid", {31'd0, ex_valid_o}, 32'd0);
    chk("post rst op1", op1_o, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- Decode-to-execute pipeline register with valid/ready handshake and a one-entry skid buffer.
- Captures decoded operands from the id stage and presents them to the combinational ex stage as registered outputs.
- Absorbs one beat of backpressure without a combinational ready path.
- Inserts a NOP bubble on flush (taken jump/branch from ctrl) or when empty.

Parameters:
- XLEN, 32, datapath width of operands and addresses.
- NOP_INST, 32'h0000_0013, instruction word presented when no valid entry (addi x0,x0,0).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- inst_i  in  32  decoded instruction word
- inst_addr_i  in  XLEN  instruction PC
- op1_i  in  XLEN  operand 1
- op2_i  in  XLEN  operand 2
- rd_addr_i  in  5  destination register
- rd_wen_i  in  1  destination write enable
- base_addr_i  in  XLEN  branch base address
- addr_offset_i  in  XLEN  branch offset
- id_valid_i  in  1  upstream entry valid
- id_ready_o  out  1  this block can accept an entry
- ex_valid_o  out  1  outputs hold a valid entry
- ex_ready_i  in  1  downstream consumes the entry
- hold_i  in  1  ctrl stall; freezes output
- flush_i  in  1  ctrl flush (jump_en from ex); discards all entries
- inst_o, inst_addr_o, op1_o, op2_o, rd_addr_o, rd_wen_o, base_addr_o, addr_offset_o  out  as inputs  registered entry to ex
- stall_cnt_o  out  32  stall cycle counter (see Optional Feature)
- flush_cnt_o  out  32  effective flush counter (see Optional Feature)

Behaviour:
- Storage:
  - Main register M drives the outputs.
  - Skid register S holds one overflow entry.
- States: EMPTY (no entry), ONE (M valid), TWO (M and S valid).
- id_ready_o = (state != TWO); depends on registered state only, with no combinational path from ex_ready_i.
- ex_valid_o = (state != EMPTY).
- Transfer rules:
  - in = id_valid_i & id_ready_o.
  - rdy = ex_ready_i & ~hold_i.
  - out = ex_valid_o & rdy.
- Transitions (flush_i low):
  - EMPTY: in -> ONE, M <= inputs.
  - ONE:
    - in & ~out -> TWO, S <= inputs.
    - ~in & out -> EMPTY.
    - in & out -> ONE, M <= inputs.
    - neither -> ONE, M unchanged.
  - TWO:
    - out -> ONE, M <= S.
    - else hold; no input accepted.
- flush_i high has highest priority:
  - Next state EMPTY; any same-cycle input transfer is discarded.
  - M and S fields are reset to NOP values.
  - hold_i is ignored during flush.
- When not valid, outputs carry NOP values: inst_o=NOP_INST, rd_wen_o=0, rd_addr_o=0, all other data fields 0. ex always sees a harmless instruction.
- Order preserved: entries leave in acceptance order; no entry is duplicated or dropped except by flush.
- Latency: an input accepted at edge N is visible on the outputs after edge N (1 cycle) when the block was EMPTY or ONE with out.
- Reset (async assert, sync-safe deassert by the top level):
  - state=EMPTY, ex_valid_o=0, id_ready_o=1.
  - Outputs at NOP values; counters 0.
  - Reset mid-operation drops all entries immediately.

Optional Feature:
- Macro ID_EX_STAT_EN.
- Defined:
  - stall_cnt_o increments each cycle ex_valid_o & ~rdy.
  - flush_cnt_o increments each cycle flush_i is high while state != EMPTY or in would occur.
  - Both counters saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: both ports are driven constant 0 and no counter flops are generated.

Test Plan:
- Reset then idle -> ex_valid_o=0, inst_o=32'h0000_0013, rd_wen_o=0, id_ready_o=1.
- Stream 3 entries (op1_i=1,2,3) with ex_ready_i=1 -> op1_o=1,2,3 on consecutive cycles, 1-cycle latency, state never TWO.
- ex_ready_i=0 while 2 entries offered -> id_ready_o drops to 0 after the 2nd; ex_ready_i=1 for 2 cycles -> op1_o=first value then second value, id_ready_o returns to 1.
- State TWO with inst_addr 0x100/0x104, pulse flush_i with id_valid_i=1 -> next cycle ex_valid_o=0, inst_o=NOP, new input not captured.
- hold_i=1 with ex_ready_i=1 and valid entry -> outputs frozen, no consumption; release -> entry consumed once.
- With ID_EX_STAT_EN: 4 stall cycles and 1 flush of valid data -> stall_cnt_o=4, flush_cnt_o=1; without the macro both read 0.
